// File: rtl/rename_map_cp.sv
// Integer rename stage: speculative RAT, circular physical free list and a ring of
// branch checkpoints that restore the RAT and free-list head in one cycle.
module rename_map_cp #(
  parameter int WIDTH    = 4,
  parameter int ARF_SIZE = 32,
  parameter int PRF_SIZE = 64,
  parameter int CP_DEPTH = 4,
  localparam int AW = $clog2(ARF_SIZE),
  localparam int PW = $clog2(PRF_SIZE),
  localparam int FD = PRF_SIZE - ARF_SIZE,
  localparam int CW = $clog2(CP_DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [WIDTH-1:0]             in_valid,
  input  logic [WIDTH-1:0][AW-1:0]     rs1,
  input  logic [WIDTH-1:0][AW-1:0]     rs2,
  input  logic [WIDTH-1:0][AW-1:0]     rd,
  input  logic [WIDTH-1:0]             rd_valid,
  input  logic                         cp_take,
  input  logic                         cp_release,
  input  logic                         recover,
  input  logic [CW-1:0]                recover_idx,
  input  logic [WIDTH-1:0]             free_valid,
  input  logic [WIDTH-1:0][PW-1:0]     free_prf,
  output logic [WIDTH-1:0][PW-1:0]     prs1,
  output logic [WIDTH-1:0][PW-1:0]     prs2,
  output logic [WIDTH-1:0][PW-1:0]     prd,
  output logic [WIDTH-1:0][PW-1:0]     prev_prd,
  output logic [WIDTH-1:0]             prev_valid,
  output logic [CW-1:0]                cp_idx,
  output logic                         fire,
  output logic                         ready,
  output logic [PW:0]                  fl_count,
  output logic                         cp_full
);

  localparam int FA  = $clog2(FD);
  localparam int FLW = FA + 1;
  localparam int CPW = CW + 1;

  typedef logic [ARF_SIZE-1:0][PW-1:0] map_t;

  map_t             rat;
  map_t             next_map;
  logic [PW-1:0]    fl_mem [FD];
  logic [FLW-1:0]   head;
  logic [FLW-1:0]   tail;
  logic [FLW-1:0]   next_head;
  logic [FLW-1:0]   next_tail;
  logic [FLW-1:0]   fl_used;
  logic [FLW-1:0]   n_alloc;
  logic [FA-1:0]    free_slot [WIDTH];

  map_t             cp_map [CP_DEPTH];
  logic [FLW-1:0]   cp_fl_head [CP_DEPTH];
  logic [CPW-1:0]   cp_head;
  logic [CPW-1:0]   cp_tail;
  logic [CPW-1:0]   cp_used;
  logic [CPW-1:0]   rec_tail;
  logic [CW-1:0]    rec_dist;
  logic             cp_empty;
  logic             release_ok;

  // Lanes are renamed in order against a running copy of the RAT, so an older lane's
  // destination is visible to younger sources and the last duplicate writer wins.
  always_comb begin
    next_map  = rat;
    next_head = head;
    for (int i = 0; i < WIDTH; i++) begin
      prs1[i]       = '0;
      prs2[i]       = '0;
      prd[i]        = '0;
      prev_prd[i]   = '0;
      prev_valid[i] = 1'b0;
      if (in_valid[i]) begin
        if (rs1[i] != '0) prs1[i] = next_map[rs1[i]];
        if (rs2[i] != '0) prs2[i] = next_map[rs2[i]];
        if (rd_valid[i] && (rd[i] != '0)) begin
          prd[i]            = fl_mem[next_head[FA-1:0]];
          prev_prd[i]       = next_map[rd[i]];
          prev_valid[i]     = 1'b1;
          next_map[rd[i]]   = fl_mem[next_head[FA-1:0]];
          next_head         = next_head + FLW'(1);
        end
      end
    end
    n_alloc = next_head - head;
  end

  // Returned registers are packed into consecutive tail slots in lane order.
  always_comb begin
    next_tail = tail;
    for (int j = 0; j < WIDTH; j++) begin
      free_slot[j] = next_tail[FA-1:0];
      if (free_valid[j]) next_tail = next_tail + FLW'(1);
    end
  end

  assign fl_used    = tail - head;
  assign fl_count   = (PW+1)'(fl_used);
  assign cp_used    = cp_tail - cp_head;
  assign cp_full    = (cp_used == CPW'(CP_DEPTH));
  assign cp_empty   = (cp_used == '0);
  assign cp_idx     = cp_tail[CW-1:0];
  assign ready      = (n_alloc <= fl_used) && !(cp_take && cp_full);
  assign fire       = (|in_valid) && ready && !stall && !recover;
  assign release_ok = cp_release && !cp_empty;

  // Recovery keeps every checkpoint older than the restored slot; a release in the
  // same cycle can never leave cp_head beyond cp_tail.
  assign rec_dist = recover_idx - cp_head[CW-1:0];
  assign rec_tail = (release_ok && (rec_dist == '0)) ? cp_head + CPW'(1)
                                                     : cp_head + {1'b0, rec_dist};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ARF_SIZE; r++) rat[r] <= PW'(r);
      for (int k = 0; k < FD; k++) fl_mem[k] <= PW'(ARF_SIZE + k);
      head    <= '0;
      tail    <= FLW'(FD);
      cp_head <= '0;
      cp_tail <= '0;
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        if (free_valid[j]) fl_mem[free_slot[j]] <= free_prf[j];
      end
      tail <= next_tail;
      if (release_ok) cp_head <= cp_head + CPW'(1);
      if (recover) begin
        rat     <= cp_map[recover_idx];
        head    <= cp_fl_head[recover_idx];
        cp_tail <= rec_tail;
      end else if (fire) begin
        rat  <= next_map;
        head <= next_head;
        if (cp_take) begin
          cp_map[cp_tail[CW-1:0]]     <= next_map;
          cp_fl_head[cp_tail[CW-1:0]] <= next_head;
          cp_tail                     <= cp_tail + CPW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_map_cp.sv
// Bench for rename_map_cp: directed scenarios plus randomized traffic, checked against an
// unbounded-list model of the free list and a queue of RAT snapshots.
module tb_rename_map_cp;

  typedef logic [31:0][5:0] mapvec_t;

  logic              clock;
  logic              reset;
  logic              stall;
  logic [3:0]        in_valid;
  logic [3:0][4:0]   rs1;
  logic [3:0][4:0]   rs2;
  logic [3:0][4:0]   rd;
  logic [3:0]        rd_valid;
  logic              cp_take;
  logic              cp_release;
  logic              recover;
  logic [1:0]        recover_idx;
  logic [3:0]        free_valid;
  logic [3:0][5:0]   free_prf;
  logic [3:0][5:0]   prs1;
  logic [3:0][5:0]   prs2;
  logic [3:0][5:0]   prd;
  logic [3:0][5:0]   prev_prd;
  logic [3:0]        prev_valid;
  logic [1:0]        cp_idx;
  logic              fire;
  logic              ready;
  logic [6:0]        fl_count;
  logic              cp_full;

  int checks;
  int passes;

  int      mmap [32];
  int      nmap [32];
  int      fq [$];
  int      hd;
  mapvec_t cp_maps [$];
  int      cp_hds [$];
  int      cp_base;
  int      e_nalloc;
  bit      e_fire;

  rename_map_cp dut (
    .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_valid(rd_valid),
    .cp_take(cp_take), .cp_release(cp_release), .recover(recover), .recover_idx(recover_idx),
    .free_valid(free_valid), .free_prf(free_prf),
    .prs1(prs1), .prs2(prs2), .prd(prd), .prev_prd(prev_prd), .prev_valid(prev_valid),
    .cp_idx(cp_idx), .fire(fire), .ready(ready), .fl_count(fl_count), .cp_full(cp_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clearInputs();
    stall = 0; in_valid = '0; rs1 = '0; rs2 = '0; rd = '0; rd_valid = '0;
    cp_take = 0; cp_release = 0; recover = 0; recover_idx = '0;
    free_valid = '0; free_prf = '0;
  endtask

  task automatic setLane(input int i, input int s1, input int s2, input int d, input bit dv);
    in_valid[i] = 1'b1;
    rs1[i] = 5'(s1);
    rs2[i] = 5'(s2);
    rd[i] = 5'(d);
    rd_valid[i] = dv;
  endtask

  // Expected outputs follow the sequential meaning of a group: lane i sees the map after lanes 0..i-1.
  task automatic applyStimulus();
    int cnt;
    int avail;
    #2;
    if (!reset) begin
      for (int r = 0; r < 32; r++) nmap[r] = mmap[r];
      cnt = 0;
      avail = fq.size() - hd;
      for (int i = 0; i < 4; i++) begin
        int e1;
        int e2;
        e1 = 0;
        e2 = 0;
        if (in_valid[i]) begin
          e1 = (rs1[i] == 0) ? 0 : nmap[rs1[i]];
          e2 = (rs2[i] == 0) ? 0 : nmap[rs2[i]];
        end
        if (e1 >= 0) checkOutput($sformatf("prs1[%0d]", i), 32'(prs1[i]), e1);
        if (e2 >= 0) checkOutput($sformatf("prs2[%0d]", i), 32'(prs2[i]), e2);
        if (in_valid[i] && rd_valid[i] && rd[i] != 0) begin
          if (nmap[rd[i]] >= 0) checkOutput($sformatf("prev_prd[%0d]", i), 32'(prev_prd[i]), nmap[rd[i]]);
          checkOutput($sformatf("prev_valid[%0d]", i), 32'(prev_valid[i]), 1);
          if (cnt < avail) begin
            checkOutput($sformatf("prd[%0d]", i), 32'(prd[i]), fq[hd + cnt]);
            nmap[rd[i]] = fq[hd + cnt];
          end else begin
            nmap[rd[i]] = -1;
          end
          cnt++;
        end else begin
          checkOutput($sformatf("prd[%0d]", i), 32'(prd[i]), 0);
          checkOutput($sformatf("prev_prd[%0d]", i), 32'(prev_prd[i]), 0);
          checkOutput($sformatf("prev_valid[%0d]", i), 32'(prev_valid[i]), 0);
        end
      end
      e_nalloc = cnt;
      e_fire = (in_valid != 0) && (cnt <= avail) && !(cp_take && cp_maps.size() == 4) && !stall && !recover;
      checkOutput("ready", 32'(ready), ((cnt <= avail) && !(cp_take && cp_maps.size() == 4)) ? 1 : 0);
      checkOutput("fire", 32'(fire), e_fire ? 1 : 0);
      checkOutput("fl_count", 32'(fl_count), avail);
      checkOutput("cp_full", 32'(cp_full), (cp_maps.size() == 4) ? 1 : 0);
      checkOutput("cp_idx", 32'(cp_idx), (cp_base + cp_maps.size()) % 4);
    end
  endtask

  task automatic stepClock();
    int pre_cp;
    int k;
    mapvec_t snap;
    if (reset) begin
      for (int r = 0; r < 32; r++) mmap[r] = r;
      fq.delete();
      for (int r = 32; r < 64; r++) fq.push_back(r);
      hd = 0;
      cp_maps.delete();
      cp_hds.delete();
      cp_base = 0;
    end else begin
      pre_cp = cp_maps.size();
      if (recover) begin
        k = (int'(recover_idx) - (cp_base % 4) + 4) % 4;
        for (int r = 0; r < 32; r++) mmap[r] = int'(cp_maps[k][r]);
        hd = cp_hds[k];
        while (cp_maps.size() > k) begin
          void'(cp_maps.pop_back());
          void'(cp_hds.pop_back());
        end
      end else if (e_fire) begin
        for (int r = 0; r < 32; r++) mmap[r] = nmap[r];
        hd += e_nalloc;
        if (cp_take) begin
          for (int r = 0; r < 32; r++) snap[r] = 6'(mmap[r]);
          cp_maps.push_back(snap);
          cp_hds.push_back(hd);
        end
      end
      if (cp_release && pre_cp > 0) begin
        if (cp_maps.size() > 0) begin
          void'(cp_maps.pop_front());
          void'(cp_hds.pop_front());
        end
        cp_base++;
      end
      for (int j = 0; j < 4; j++) if (free_valid[j]) fq.push_back(int'(free_prf[j]));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    applyStimulus();
    stepClock();
    reset = 1'b0;
  endtask

  initial begin
    int allowed;
    int min_hd;
    checks = 0;
    passes = 0;
    reset = 1'b0;
    clearInputs();
    @(posedge clock);
    #1;
    doReset();

    // Idle state after reset, then basic rename with bypass
    applyStimulus();
    checkOutput("reset fl_count", 32'(fl_count), 32);
    stepClock();
    setLane(0, 5, 0, 5, 1);
    setLane(1, 5, 0, 0, 0);
    applyStimulus();
    checkOutput("t1 prs1[0]", 32'(prs1[0]), 5);
    checkOutput("t1 prd[0]", 32'(prd[0]), 32);
    checkOutput("t1 prev_prd[0]", 32'(prev_prd[0]), 5);
    checkOutput("t1 prs1[1]", 32'(prs1[1]), 32);
    stepClock();
    clearInputs();
    applyStimulus();
    checkOutput("t1 fl_count", 32'(fl_count), 31);
    stepClock();

    // x0 destination and duplicate rd in one group
    doReset();
    setLane(0, 0, 0, 0, 1);
    setLane(1, 0, 0, 3, 1);
    setLane(2, 0, 0, 3, 1);
    applyStimulus();
    checkOutput("t2 prd[0]", 32'(prd[0]), 0);
    checkOutput("t2 prev_valid[0]", 32'(prev_valid[0]), 0);
    checkOutput("t2 prd[1]", 32'(prd[1]), 32);
    checkOutput("t2 prd[2]", 32'(prd[2]), 33);
    checkOutput("t2 prev_prd[2]", 32'(prev_prd[2]), 32);
    stepClock();
    clearInputs();
    setLane(0, 3, 0, 0, 0);
    applyStimulus();
    checkOutput("t2 rat3", 32'(prs1[0]), 33);
    stepClock();

    // Exhaustion, then a free makes the held group ready
    doReset();
    for (int g = 0; g < 8; g++) begin
      clearInputs();
      for (int i = 0; i < 4; i++) setLane(i, 0, 0, i + 1, 1);
      applyStimulus();
      stepClock();
    end
    clearInputs();
    setLane(0, 0, 0, 9, 1);
    free_valid[0] = 1'b1;
    free_prf[0] = 6'd7;
    applyStimulus();
    checkOutput("t3 fl_count", 32'(fl_count), 0);
    checkOutput("t3 ready held", 32'(ready), 0);
    checkOutput("t3 fire held", 32'(fire), 0);
    stepClock();
    free_valid = '0;
    applyStimulus();
    checkOutput("t3 ready", 32'(ready), 1);
    checkOutput("t3 prd", 32'(prd[0]), 7);
    stepClock();

    // Checkpoint and recover
    doReset();
    setLane(0, 0, 0, 1, 1);
    cp_take = 1'b1;
    applyStimulus();
    checkOutput("t4 cp_idx", 32'(cp_idx), 0);
    checkOutput("t4 prd A", 32'(prd[0]), 32);
    stepClock();
    clearInputs();
    setLane(0, 0, 0, 4, 1);
    applyStimulus();
    checkOutput("t4 prd B", 32'(prd[0]), 33);
    stepClock();
    clearInputs();
    recover = 1'b1;
    recover_idx = 2'd0;
    applyStimulus();
    stepClock();
    clearInputs();
    setLane(0, 4, 0, 4, 1);
    applyStimulus();
    checkOutput("t4 fl_count", 32'(fl_count), 31);
    checkOutput("t4 rat4", 32'(prs1[0]), 4);
    checkOutput("t4 prd again", 32'(prd[0]), 33);
    stepClock();

    // Checkpoint buffer full
    doReset();
    for (int c = 0; c < 4; c++) begin
      clearInputs();
      setLane(0, 0, 0, 1, 1);
      cp_take = 1'b1;
      applyStimulus();
      stepClock();
    end
    clearInputs();
    setLane(0, 0, 0, 2, 1);
    cp_take = 1'b1;
    cp_release = 1'b1;
    applyStimulus();
    checkOutput("t5 cp_full", 32'(cp_full), 1);
    checkOutput("t5 fire held", 32'(fire), 0);
    stepClock();
    cp_release = 1'b0;
    applyStimulus();
    checkOutput("t5 fire", 32'(fire), 1);
    checkOutput("t5 cp_idx", 32'(cp_idx), 0);
    stepClock();

    // Stall and recover alongside frees, then reset mid-stream
    doReset();
    for (int i = 0; i < 4; i++) setLane(i, 0, 0, i + 1, 1);
    cp_take = 1'b1;
    applyStimulus();
    stepClock();
    clearInputs();
    setLane(0, 0, 0, 5, 1);
    setLane(1, 0, 0, 6, 1);
    applyStimulus();
    stepClock();
    clearInputs();
    stall = 1'b1;
    setLane(0, 0, 0, 7, 1);
    free_valid = 4'b0011;
    free_prf[0] = 6'd40;
    free_prf[1] = 6'd41;
    applyStimulus();
    checkOutput("t6 stall fire", 32'(fire), 0);
    stepClock();
    clearInputs();
    setLane(0, 1, 7, 0, 0);
    applyStimulus();
    checkOutput("t6 fl_count stall", 32'(fl_count), 28);
    checkOutput("t6 rat7", 32'(prs2[0]), 7);
    stepClock();
    clearInputs();
    recover = 1'b1;
    recover_idx = 2'd0;
    free_valid[0] = 1'b1;
    free_prf[0] = 6'd42;
    applyStimulus();
    stepClock();
    clearInputs();
    setLane(0, 5, 0, 0, 0);
    applyStimulus();
    checkOutput("t6 fl_count recover", 32'(fl_count), 31);
    checkOutput("t6 rat5", 32'(prs1[0]), 5);
    stepClock();
    clearInputs();
    setLane(0, 0, 0, 9, 1);
    cp_take = 1'b1;
    doReset();
    setLane(0, 5, 0, 5, 1);
    applyStimulus();
    checkOutput("t6 reset fl_count", 32'(fl_count), 32);
    checkOutput("t6 reset cp_full", 32'(cp_full), 0);
    checkOutput("t6 reset prd", 32'(prd[0]), 32);
    stepClock();

    // Randomized traffic; frees are bounded so a later recover can never overflow the list
    for (int n = 0; n < 3000; n++) begin
      clearInputs();
      reset = ($urandom_range(0, 299) == 0);
      stall = ($urandom_range(0, 6) == 0);
      in_valid = 4'($urandom_range(0, 15));
      rd_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        rs1[i] = 5'($urandom_range(0, 31));
        rs2[i] = 5'($urandom_range(0, 31));
        rd[i] = 5'($urandom_range(0, 31));
      end
      cp_take = ($urandom_range(0, 2) == 0);
      cp_release = ($urandom_range(0, 7) == 0);
      if (cp_maps.size() > 0 && $urandom_range(0, 14) == 0) begin
        recover = 1'b1;
        recover_idx = 2'((cp_base + $urandom_range(0, cp_maps.size() - 1)) % 4);
      end
      min_hd = hd;
      foreach (cp_hds[q]) if (cp_hds[q] < min_hd) min_hd = cp_hds[q];
      allowed = 32 - (fq.size() - min_hd);
      for (int j = 0; j < 4; j++) begin
        if (allowed > 0 && $urandom_range(0, 1) == 1) begin
          free_valid[j] = 1'b1;
          free_prf[j] = 6'($urandom_range(1, 63));
          allowed--;
        end
      end
      applyStimulus();
      stepClock();
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
